// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM-style pipeline: FSM state encoding,
// data-memory defaults, and word/register widths.
package arm_pkg;

    localparam int WORD_W        = 32;
    localparam int REG_W         = 4;
    localparam int CNT_W         = 4;
    localparam int DEF_MEM_WORDS = 64;
    localparam int DEF_BASE_ADDR = 1024;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    // MEM/WB pipeline register contents.
    typedef struct packed {
        logic [WORD_W-1:0] alu;
        logic [WORD_W-1:0] mem_data;
        logic [REG_W-1:0]  dst;
        logic              mem_r;
        logic              wb_en;
    } memwb_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are deliberately left unreset.
module data_memory
    import arm_pkg::*;
#(
    parameter int WORDS = DEF_MEM_WORDS,
    parameter int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data-memory access with a wait-state FSM,
// a stall signal back to EXE, and the MEM/WB output register.
module mem_stage
    import arm_pkg::*;
#(
    parameter int MEM_WORDS   = DEF_MEM_WORDS,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = 3              // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] ALU_res,
    input  logic [WORD_W-1:0] val_Rm,
    input  logic [REG_W-1:0]  dst,
    input  logic              mem_R,
    input  logic              mem_W,
    input  logic              WB_en,
    output logic              ready,
    output logic [WORD_W-1:0] ALU_res_out,
    output logic [WORD_W-1:0] mem_data_out,
    output logic [REG_W-1:0]  dst_out,
    output logic              mem_R_out,
    output logic              WB_en_out,
    output state_e            dbg_state_o,
    output logic [CNT_W-1:0]  dbg_cnt_o
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    memwb_t            out_q, out_d;

    logic              mem_op;
    logic              is_load;
    logic              below_base;
    logic              in_range;
    logic [WORD_W-1:0] offset;
    logic [WORD_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // A store wins when both mem_R and mem_W are set.
    assign mem_op  = mem_R | mem_W;
    assign is_load = mem_R & ~mem_W;

    // Byte address to word index; the two low address bits are dropped.
    assign below_base = ALU_res < WORD_W'(BASE_ADDR);
    assign offset     = ALU_res - WORD_W'(BASE_ADDR);
    assign word_idx   = offset >> 2;
    assign in_range   = !below_base && (word_idx < WORD_W'(MEM_WORDS));
    assign mem_idx    = word_idx[IDX_W-1:0];

    data_memory #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .idx   (mem_idx),
        .wdata (val_Rm),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ready   = 1'b1;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    ready       = 1'b0;
                    state_d     = S_WAIT;
                    cnt_d       = CNT_W'(WAIT_CYCLES - 1);
                    out_d.wb_en = 1'b0;
                    out_d.mem_r = 1'b0;
                end else begin
                    out_d.alu   = ALU_res;
                    out_d.dst   = dst;
                    out_d.wb_en = WB_en;
                    out_d.mem_r = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    ready = 1'b0;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Completing edge: inputs sampled now are the ones used.
                    state_d     = S_IDLE;
                    out_d.alu   = ALU_res;
                    out_d.dst   = dst;
                    out_d.wb_en = WB_en;
                    out_d.mem_r = is_load;
                    if (is_load) begin
                        out_d.mem_data = in_range ? mem_rdata : '0;
                    end
                    // Reset at this edge aborts the store.
                    mem_we = mem_W & in_range & ~rst;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign ALU_res_out  = out_q.alu;
    assign mem_data_out = out_q.mem_data;
    assign dst_out      = out_q.dst;
    assign mem_R_out    = out_q.mem_r;
    assign WB_en_out    = out_q.wb_en;
    assign dbg_state_o  = state_q;
    assign dbg_cnt_o    = cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_mem_stage;
    import arm_pkg::*;

    localparam int WORDS = 64;
    localparam int BASE  = 1024;
    localparam int WAITC = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] ALU_res = '0;
    logic [31:0] val_Rm  = '0;
    logic [3:0]  dst     = '0;
    logic        mem_R   = 1'b0;
    logic        mem_W   = 1'b0;
    logic        WB_en   = 1'b0;
    logic        ready;
    logic [31:0] ALU_res_out;
    logic [31:0] mem_data_out;
    logic [3:0]  dst_out;
    logic        mem_R_out;
    logic        WB_en_out;
    state_e      dbg_state;
    logic [3:0]  dbg_cnt;

    mem_stage #(
        .MEM_WORDS   (WORDS),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ALU_res      (ALU_res),
        .val_Rm       (val_Rm),
        .dst          (dst),
        .mem_R        (mem_R),
        .mem_W        (mem_W),
        .WB_en        (WB_en),
        .ready        (ready),
        .ALU_res_out  (ALU_res_out),
        .mem_data_out (mem_data_out),
        .dst_out      (dst_out),
        .mem_R_out    (mem_R_out),
        .WB_en_out    (WB_en_out),
        .dbg_state_o  (dbg_state),
        .dbg_cnt_o    (dbg_cnt)
    );

    // reference model state
    logic [31:0] mem_m [WORDS];
    logic [31:0] exp_alu = '0;
    logic [31:0] exp_md  = '0;
    logic [3:0]  exp_dst = '0;
    logic        exp_wb  = 1'b0;
    logic        exp_mr  = 1'b0;
    logic        exp_ready = 1'b1;
    bit          chk_en = 1'b0;
    logic [7:0]  rdy_hist = '0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        rdy_hist = {rdy_hist[6:0], ready};
        if (chk_en) begin
            check("ready",        32'(ready),     32'(exp_ready));
            check("ALU_res_out",  ALU_res_out,    exp_alu);
            check("mem_data_out", mem_data_out,   exp_md);
            check("dst_out",      32'(dst_out),   32'(exp_dst));
            check("WB_en_out",    32'(WB_en_out), 32'(exp_wb));
            check("mem_R_out",    32'(mem_R_out), 32'(exp_mr));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] v, input logic [3:0] d,
                         input logic r, input logic w, input logic wb);
        ALU_res = a;
        val_Rm  = v;
        dst     = d;
        mem_R   = r;
        mem_W   = w;
        WB_en   = wb;
    endtask

    // Transaction-level effect of one completed instruction.
    task automatic model_apply(input logic [31:0] a, input logic [31:0] v, input logic [3:0] d,
                               input logic r, input logic w, input logic wb);
        longint la = longint'(a);
        bit     in_rng;
        int     idx;
        in_rng  = (la >= BASE) && (la < BASE + 4 * WORDS);
        idx     = in_rng ? int'((la - BASE) / 4) : 0;
        exp_alu = a;
        exp_dst = d;
        exp_wb  = wb;
        exp_mr  = r & ~w;
        if (w) begin
            if (in_rng) mem_m[idx] = v;
        end else if (r) begin
            exp_md = in_rng ? mem_m[idx] : 32'h0;
        end
    endtask

    // Memory op: ready low WAITC cycles, bubble after the first edge, then complete.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] v, input logic [3:0] d,
                          input logic r, input logic w, input logic wb, input bit jitter);
        int n = (r | w) ? WAITC : 0;
        drive(a, v, d, r, w, wb);
        for (int i = 0; i < n; i++) begin
            exp_ready = 1'b0;
            tick();
            if (i == 0) begin
                exp_wb = 1'b0;
                exp_mr = 1'b0;
            end
            if (jitter) begin
                if (i == n - 1) drive(a, v, d, r, w, wb);
                else            drive($urandom, $urandom, 4'($urandom), r, w, 1'($urandom));
            end
        end
        exp_ready = 1'b1;
        tick();
        model_apply(a, v, d, r, w, wb);
    endtask

    task automatic idle();
        do_txn(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // scoreboard-free watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          kind;

        // reset
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        check("rst_alu",   ALU_res_out,  32'h0);
        check("rst_md",    mem_data_out, 32'h0);
        check("rst_wb",    32'(WB_en_out), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst    = 1'b0;
        chk_en = 1'b1;

        // plain ALU pass-through
        do_txn(32'h55, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("alu_pass_alu", ALU_res_out, 32'h55);
        check("alu_pass_dst", 32'(dst_out), 32'd3);
        check("alu_pass_wb",  32'(WB_en_out), 32'd1);

        // fill memory so every later load has a known value
        for (int i = 0; i < WORDS; i++)
            do_txn(32'(BASE + 4 * i), 32'hA500_0000 + 32'(i), 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // store then load 1028
        do_txn(32'd1028, 32'hDEAD_BEEF, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn(32'd1028, 32'h0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ld1028_data", mem_data_out, 32'hDEAD_BEEF);
        check("ld1028_mr",   32'(mem_R_out), 32'd1);

        // mem_R and mem_W both set: store
        do_txn(32'd1032, 32'd7, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        check("both_mr", 32'(mem_R_out), 32'd0);
        do_txn(32'd1032, 32'h0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ld1032_data", mem_data_out, 32'd7);

        // out of range accesses
        do_txn(32'(BASE + 4 * WORDS), 32'h1111_2222, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        do_txn(32'd1000, 32'h0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ld1000_data", mem_data_out, 32'h0);
        check("ld1000_wb",   32'(WB_en_out), 32'd1);
        do_txn(32'd1024, 32'h0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ld_word0_data", mem_data_out, 32'hA500_0000);
        do_txn(32'(BASE + 4 * WORDS), 32'h0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ld_oor_hi_data", mem_data_out, 32'h0);

        // reset during the second WAIT cycle of a store to 1040
        do_txn(32'd1040, 32'h1234_5678, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(32'd1040, 32'hBAD0_BAD0, 4'd9, 1'b0, 1'b1, 1'b1);
        exp_ready = 1'b0;
        tick();
        exp_wb = 1'b0;
        exp_mr = 1'b0;
        tick();
        chk_en = 1'b0;
        rst    = 1'b1;
        tick();
        check("abort_alu",   ALU_res_out,  32'h0);
        check("abort_dst",   32'(dst_out), 32'h0);
        check("abort_md",    mem_data_out, 32'h0);
        check("abort_state", 32'(dbg_state), 32'(S_IDLE));
        check("abort_cnt",   32'(dbg_cnt), 32'h0);
        rst = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        exp_alu = '0; exp_md = '0; exp_dst = '0; exp_wb = 1'b0; exp_mr = 1'b0;
        exp_ready = 1'b1;
        chk_en = 1'b1;
        do_txn(32'd1040, 32'h0, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ld1040_after_abort", mem_data_out, 32'h1234_5678);

        // two back-to-back loads
        do_txn(32'd1044, 32'h0, 4'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        check("b2b_first", mem_data_out, 32'hA500_0005);
        do_txn(32'd1048, 32'h0, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        check("b2b_second", mem_data_out, 32'hA500_0006);
        check("b2b_ready_pattern", 32'(rdy_hist), 32'h11);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0:       a = 32'($urandom_range(0, BASE - 1));
                1:       a = 32'(BASE + 4 * WORDS) + 32'($urandom_range(0, 4095));
                2:       a = $urandom;
                default: a = 32'(BASE) + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 3))
                0: do_txn(a, $urandom, 4'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b0);
                1: do_txn(a, $urandom, 4'($urandom), 1'b1, 1'b0, 1'($urandom), ($urandom_range(0, 3) == 0));
                2: do_txn(a, $urandom, 4'($urandom), 1'b0, 1'b1, 1'($urandom), ($urandom_range(0, 3) == 0));
                default: do_txn(a, $urandom, 4'($urandom), 1'b1, 1'b1, 1'($urandom), 1'b0);
            endcase
        end

        // read back every word against the model
        for (int i = 0; i < WORDS; i++)
            do_txn(32'(BASE + 4 * i), 32'h0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
